// File: rtl/lcd_pkg.sv
// Shared constants and the read-side state encoding for the UART-to-LCD row path.
package lcd_pkg;

  localparam int         ROW_BYTES = 480;    // bytes per display row (one bank depth)
  localparam int         ROWS      = 320;    // rows per frame
  localparam int         ADDR_W    = 9;      // bank address width
  localparam logic [7:0] ACK_BYTE  = 8'h41;  // 'A' grants the host one row

  // Read FSM: wait for a full bank, then wait for the LCD to finish drawing it.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DRAW = 1'b1
  } rd_state_e;

  // Next display row index, wrapping at the end of the frame.
  function automatic logic [8:0] row_next(input logic [8:0] y, input int rows);
    if (y == 9'(rows - 1)) begin
      return 9'd0;
    end
    return y + 9'd1;
  endfunction

endpackage

// File: rtl/ack_credit_tx.sv
// Saturating row-credit counter and the ack-byte transmit handshake.
// Handshake: tx_valid is raised only while credit is available and is held,
// together with tx_data, until a cycle with tx_ready=1; that cycle is the
// transfer. tx_valid then drops for at least one cycle before the next ack.
module ack_credit_tx #(
  parameter logic [7:0] ACK_VAL = 8'h41
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       credit_inc,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data
);

  logic [1:0] credit_q, credit_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_accept;

  // Next credit count and ack request, saturating at two outstanding rows.
  always_comb begin
    tx_accept  = tx_valid_q && tx_ready;
    credit_d   = credit_q;
    tx_valid_d = tx_valid_q;
    unique case ({credit_inc, tx_accept})
      2'b10:   credit_d = (credit_q == 2'd2) ? 2'd2 : credit_q + 2'd1;
      2'b01:   credit_d = credit_q - 2'd1;
      default: credit_d = credit_q;
    endcase
    if (tx_accept) begin
      tx_valid_d = 1'b0;
    end else if (!tx_valid_q && (credit_q != 2'd0)) begin
      tx_valid_d = 1'b1;
    end
    tx_data_d = tx_valid_d ? ACK_VAL : 8'h00;
  end

  // Credit register starts at one so the power-up grant goes out after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_q   <= 2'd1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      credit_q   <= credit_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/row_pingpong_sched.sv
// Ping-pong scheduler for two row banks: UART bytes fill one bank while the
// LCD draws the other; row credits go back to the host as ack bytes.
module row_pingpong_sched
  import lcd_pkg::*;
#(
  parameter int         ROW_LEN    = ROW_BYTES,
  parameter int         FRAME_ROWS = ROWS,
  parameter logic [7:0] ACK_VAL    = ACK_BYTE,
  parameter int         AW         = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_bank,
  output logic          row_start,
  output logic [8:0]    row_y,
  input  logic          show_row_done,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          frame_done,
  output logic          overrun,
  output rd_state_e     dbg_rd_state
);

  // Write side.
  logic [AW-1:0] ptr_q, ptr_d;
  logic          fill_bank_q, fill_bank_d;
  logic [1:0]    full_q, full_d;
  logic          wr_en_q, wr_en_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          overrun_q, overrun_d;
  logic          defer_q, defer_d;

  // Read side.
  rd_state_e     state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic          row_start_q, row_start_d;
  logic [8:0]    row_y_q, row_y_d;
  logic          frame_done_q, frame_done_d;

  // Event decode.
  logic byte_accept;
  logic row_last;
  logic new_fill;
  logic free_ev;
  logic comp_ack;
  logic comp_defer;
  logic defer_hit;
  logic ack_inc;

  // Decode accepts, row completion, bank release and the ack decision.
  // A deferred ack is owed when the bank we just switched to is still being
  // drawn; it is paid when the LCD releases exactly that bank. If release and
  // completion coincide on that bank, only one credit results.
  always_comb begin
    byte_accept = rx_valid && !full_q[fill_bank_q];
    row_last    = byte_accept && (ptr_q == AW'(ROW_LEN - 1));
    new_fill    = ~fill_bank_q;
    free_ev     = (state_q == RD_DRAW) && show_row_done;
    comp_ack    = row_last && !full_q[new_fill];
    comp_defer  = row_last && full_q[new_fill];
    defer_hit   = free_ev &&
                  ((defer_q && (rd_bank_q == fill_bank_q)) ||
                   (comp_defer && (rd_bank_q == new_fill)));
    ack_inc     = comp_ack || defer_hit;
    defer_d     = (defer_q || comp_defer) && !defer_hit;
  end

  // Write-side next state: byte capture, pointer wrap, bank flags, overrun.
  always_comb begin
    ptr_d       = ptr_q;
    fill_bank_d = fill_bank_q;
    full_d      = full_q;
    wr_en_d     = byte_accept;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    overrun_d   = overrun_q || (rx_valid && full_q[fill_bank_q]);
    if (byte_accept) begin
      wr_bank_d = fill_bank_q;
      wr_addr_d = ptr_q;
      wr_data_d = rx_data;
      ptr_d     = row_last ? '0 : ptr_q + AW'(1);
    end
    if (row_last) begin
      full_d[fill_bank_q] = 1'b1;
      fill_bank_d         = new_fill;
    end
    // Never the bank just completed: that one was the fill bank, not rd_bank.
    if (free_ev) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Read FSM next state: start a row when its bank is full, retire it on done.
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    row_start_d  = 1'b0;
    row_y_d      = row_y_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          row_start_d = 1'b1;
          state_d     = RD_DRAW;
        end
      end
      RD_DRAW: begin
        if (show_row_done) begin
          rd_bank_d    = ~rd_bank_q;
          row_y_d      = row_next(row_y_q, FRAME_ROWS);
          frame_done_d = (row_y_q == 9'(FRAME_ROWS - 1));
          state_d      = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Write-side registers; reset drops any partial row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      fill_bank_q <= 1'b0;
      full_q      <= 2'b00;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
      defer_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      fill_bank_q <= fill_bank_d;
      full_q      <= full_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      overrun_q   <= overrun_d;
      defer_q     <= defer_d;
    end
  end

  // Read FSM with its registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      rd_bank_q    <= 1'b0;
      row_start_q  <= 1'b0;
      row_y_q      <= 9'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      row_start_q  <= row_start_d;
      row_y_q      <= row_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  ack_credit_tx #(
    .ACK_VAL (ACK_VAL)
  ) u_ack (
    .clk        (clk),
    .rst_n      (rst_n),
    .credit_inc (ack_inc),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data)
  );

  assign wr_en        = wr_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rd_bank      = rd_bank_q;
  assign row_start    = row_start_q;
  assign row_y        = row_y_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
  assign dbg_rd_state = state_q;

endmodule

// File: tb/tb_row_pingpong_sched.sv
// Directed bench for row_pingpong_sched: a full-size instance for the row,
// ack and overrun scenarios, and a short-row instance for a whole frame.
module tb_row_pingpong_sched;
  import lcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic       rst_n, rx_valid, show_row_done, tx_ready;
  logic [7:0] rx_data;
  logic       wr_en, wr_bank, rd_bank, row_start, tx_valid, frame_done, overrun;
  logic [8:0] wr_addr, row_y;
  logic [7:0] wr_data, tx_data;
  rd_state_e  dbg_state;

  // short-row instance (8 bytes per row) for the frame test
  logic       f_rst_n, f_rx_valid, f_show, f_tx_ready;
  logic [7:0] f_rx_data;
  logic       f_wr_en, f_wr_bank, f_rd_bank, f_row_start, f_tx_valid, f_frame_done, f_overrun;
  logic [8:0] f_wr_addr, f_row_y;
  logic [7:0] f_wr_data, f_tx_data;
  rd_state_e  f_dbg;

  row_pingpong_sched dut (
    .clk (clk), .rst_n (rst_n), .rx_valid (rx_valid), .rx_data (rx_data),
    .wr_en (wr_en), .wr_bank (wr_bank), .wr_addr (wr_addr), .wr_data (wr_data),
    .rd_bank (rd_bank), .row_start (row_start), .row_y (row_y),
    .show_row_done (show_row_done), .tx_valid (tx_valid), .tx_data (tx_data),
    .tx_ready (tx_ready), .frame_done (frame_done), .overrun (overrun),
    .dbg_rd_state (dbg_state)
  );

  row_pingpong_sched #(.ROW_LEN(8)) dut_f (
    .clk (clk), .rst_n (f_rst_n), .rx_valid (f_rx_valid), .rx_data (f_rx_data),
    .wr_en (f_wr_en), .wr_bank (f_wr_bank), .wr_addr (f_wr_addr), .wr_data (f_wr_data),
    .rd_bank (f_rd_bank), .row_start (f_row_start), .row_y (f_row_y),
    .show_row_done (f_show), .tx_valid (f_tx_valid), .tx_data (f_tx_data),
    .tx_ready (f_tx_ready), .frame_done (f_frame_done), .overrun (f_overrun),
    .dbg_rd_state (f_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];   // {bank, addr, data} expected write beats
  int ack_cnt   = 0;
  int txv_cyc   = 0;
  int f_ack_cnt = 0;
  int f_wr_cnt  = 0;
  int f_frame_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: write beats, ack transfers, idle tx_data.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) check_eq("wr_unexpected", 32'(wr_en), 32'd0);
      else check_eq("wr_beat", 32'({wr_bank, wr_addr, wr_data}), 32'(exp_q.pop_front()));
    end
    if (tx_valid && tx_ready) ack_cnt++;
    if (tx_valid) txv_cyc++;
    check_eq("tx_data", 32'(tx_data), tx_valid ? 32'h41 : 32'h0);
    if (f_wr_en) f_wr_cnt++;
    if (f_tx_valid && f_tx_ready) f_ack_cnt++;
    if (f_frame_done) f_frame_cnt++;
    check_eq("f_tx_data", 32'(f_tx_data), f_tx_valid ? 32'h41 : 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n back-to-back bytes into the full-size instance starting at ptr 0.
  task automatic send_main(input int n, input logic bank, input int mode, input bit expect_wr);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (mode == 0) ? 8'(i % 224) : (8'(i) ^ 8'hA5);
      rx_valid = 1'b1;
      rx_data  = d;
      if (expect_wr) exp_q.push_back({bank, 9'(i), d});
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_f_row(input int r);
    for (int i = 0; i < 8; i++) begin
      f_rx_valid = 1'b1;
      f_rx_data  = 8'(r);
      tick();
    end
    f_rx_valid = 1'b0;
  endtask

  task automatic wait_f_start();
    int n;
    n = 0;
    while (!f_row_start && n < 10) begin
      tick();
      n++;
    end
    if (!f_row_start) check_eq("f_start_timeout", 32'(f_row_start), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int hold_ok;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; show_row_done = 1'b0; tx_ready = 1'b1;
    f_rst_n = 1'b0; f_rx_valid = 1'b0; f_rx_data = 8'h00; f_show = 1'b0; f_tx_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_outs", 32'({wr_en, tx_valid, row_start, rd_bank, frame_done, overrun, row_y}), 32'd0);

    // power-up grant: exactly one ack cycle
    rst_n = 1'b1;
    repeat (6) tick();
    check_eq("pwr_ack_cnt", 32'(ack_cnt), 32'd1);
    check_eq("pwr_txv_cyc", 32'(txv_cyc), 32'd1);
    check_eq("pwr_row_y", 32'(row_y), 32'd0);
    check_eq("pwr_overrun", 32'(overrun), 32'd0);

    // row 0 into bank A, row_start two edges after the last byte
    send_main(480, 1'b0, 0, 1'b1);
    check_eq("start_early", 32'(row_start), 32'd0);
    tick();
    check_eq("start_a", 32'(row_start), 32'd1);
    check_eq("start_a_bank", 32'(rd_bank), 32'd0);
    check_eq("state_draw", 32'(dbg_state), 32'(RD_DRAW));
    tick();
    check_eq("start_pulse", 32'(row_start), 32'd0);
    repeat (4) tick();
    check_eq("row0_ack", 32'(ack_cnt), 32'd2);
    check_eq("row0_beats", 32'(exp_q.size()), 32'd0);

    // row 1 into bank B while A is drawn: ack deferred
    send_main(480, 1'b1, 1, 1'b1);
    repeat (5) tick();
    check_eq("defer_no_ack", 32'(ack_cnt), 32'd2);
    check_eq("defer_rd_bank", 32'(rd_bank), 32'd0);
    show_row_done = 1'b1;
    tick();
    show_row_done = 1'b0;
    check_eq("free_rd_bank", 32'(rd_bank), 32'd1);
    check_eq("free_row_y", 32'(row_y), 32'd1);
    tick();
    check_eq("defer_ack_txv", 32'(tx_valid), 32'd1);
    check_eq("start_b", 32'(row_start), 32'd1);
    repeat (3) tick();
    check_eq("defer_ack_cnt", 32'(ack_cnt), 32'd3);

    // fill A again, then one extra byte with both banks full
    send_main(480, 1'b0, 0, 1'b1);
    send_main(1, 1'b0, 0, 1'b0);
    repeat (3) tick();
    check_eq("overrun_set", 32'(overrun), 32'd1);
    check_eq("overrun_no_ack", 32'(ack_cnt), 32'd3);
    check_eq("overrun_beats", 32'(exp_q.size()), 32'd0);

    // credit pending while the transmitter stalls for 50 cycles
    tx_ready = 1'b0;
    show_row_done = 1'b1;
    tick();
    show_row_done = 1'b0;
    tick();
    hold_ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid === 1'b1 && tx_data === 8'h41) hold_ok++;
      tick();
    end
    check_eq("stall_hold", 32'(hold_ok), 32'd50);
    check_eq("stall_no_accept", 32'(ack_cnt), 32'd3);
    tx_ready = 1'b1;
    tick();
    check_eq("stall_drop", 32'(tx_valid), 32'd0);
    check_eq("stall_accept", 32'(ack_cnt), 32'd4);
    repeat (4) tick();
    check_eq("stall_single", 32'(ack_cnt), 32'd4);
    check_eq("overrun_sticky", 32'(overrun), 32'd1);
    check_eq("row_y_two", 32'(row_y), 32'd2);

    // reset clears overrun and re-issues the power-up grant
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("overrun_clr", 32'(overrun), 32'd0);
    repeat (4) tick();
    check_eq("rst_ack", 32'(ack_cnt), 32'd5);
    check_eq("rst_row_y", 32'(row_y), 32'd0);

    // reset after 100 bytes: next row restarts at bank A, address 0
    send_main(100, 1'b0, 0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_main(2, 1'b0, 1, 1'b1);
    repeat (3) tick();
    check_eq("restart_beats", 32'(exp_q.size()), 32'd0);
    check_eq("restart_addr", 32'({wr_bank, wr_addr}), 32'd1);

    // full frame on the short-row instance
    f_rst_n = 1'b1;
    tick();
    for (int r = 0; r < 320; r++) begin
      if (r == 319) begin
        check_eq("f_row_y_last", 32'(f_row_y), 32'd319);
        check_eq("f_no_early_frame", 32'(f_frame_cnt), 32'd0);
      end
      send_f_row(r);
      wait_f_start();
      f_show = 1'b1;
      tick();
      f_show = 1'b0;
      if (r == 319) begin
        check_eq("f_frame_pulse", 32'(f_frame_done), 32'd1);
        check_eq("f_row_y_wrap", 32'(f_row_y), 32'd0);
      end
    end
    repeat (4) tick();
    check_eq("f_frame_once", 32'(f_frame_cnt), 32'd1);
    check_eq("f_wr_cnt", 32'(f_wr_cnt), 32'd2560);
    check_eq("f_acks", 32'(f_ack_cnt), 32'd321);
    check_eq("f_last_beat", 32'({f_wr_bank, f_wr_addr, f_wr_data}), 32'({1'b1, 9'd7, 8'h3F}));
    check_eq("f_end_state", 32'({f_rd_bank, f_overrun, f_dbg}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_pingpong_sched.md
Name: row_pingpong_sched

Overview:
- Sequences the UART-to-LCD row path through two row-RAM banks, A and B, in ping-pong fashion.
- The UART byte stream fills one bank while the LCD engine drains the other.
- Issues the 'A' (0x41) flow-control byte back to the host whenever a bank is free for the next row.
- Tracks the displayed row index and frame boundaries, and flags host overruns.

Parameters:
- ROW_BYTES, 480, bytes per display row (one bank depth).
- ROWS, 320, rows per frame.
- ACK_BYTE, 8'h41, byte transmitted to grant the host one row.
- ADDR_W, 9, bank address width (must hold ROW_BYTES-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, received byte valid (already in clk domain).
- rx_data  in  8  received byte.
- wr_en  out  1  bank write strobe.
- wr_bank  out  1  bank being written (0=A, 1=B).
- wr_addr  out  ADDR_W  write address within bank.
- wr_data  out  8  write data.
- rd_bank  out  1  bank the LCD must read.
- row_start  out  1  one-cycle pulse: LCD may begin drawing rd_bank.
- row_y  out  9  display row index of the row being/next drawn.
- show_row_done  in  1  one-cycle pulse from the LCD: current row fully drawn.
- tx_valid  out  1  ack byte request.
- tx_data  out  8  ack byte.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- frame_done  out  1  one-cycle pulse after row ROWS-1 is drawn.
- overrun  out  1  sticky: byte arrived with no bank available.

Behaviour:
- Reset (rst_n low at a clk edge) clears all state: outputs 0, both banks empty, fill_bank=0, rd_bank=0, row_y=0, write pointer 0, ack credit count 1. The power-up grant is therefore sent right after reset. Reset mid-row discards the partial row.
- Write side, byte accepted when rx_valid=1 and bank[fill_bank] is not full:
  - wr_en=1 next cycle, with wr_bank=fill_bank, wr_addr=ptr, wr_data=rx_data (1-cycle latency, all registered).
  - ptr increments per accepted byte.
  - At ptr==ROW_BYTES-1: ptr wraps to 0, full[fill_bank] is set, fill_bank toggles.
- Ack policy:
  - At row completion, if the newly selected fill bank is empty, ack credit +1.
  - Otherwise the ack is deferred: it is granted at the show_row_done that frees that bank.
  - The credit count saturates at 2.
- Overrun: rx_valid while bank[fill_bank] is full. The byte is dropped (no wr_en), ptr is unchanged, and overrun is set and held until reset.
- Ack TX:
  - When credit>0 and tx_valid=0, drive tx_valid=1 and tx_data=ACK_BYTE.
  - Hold until a cycle with tx_ready=1; then credit −1 and tx_valid=0 for at least one cycle.
  - tx_data=0 when idle.
- Read FSM:
  - IDLE: if full[rd_bank], pulse row_start (1 cycle) -> DRAW.
  - DRAW: wait for show_row_done, then clear full[rd_bank], toggle rd_bank, and row_y+1 -> IDLE.
  - At row_y==ROWS-1, row_y wraps to 0 and frame_done pulses on the same edge.
  - show_row_done while in IDLE is ignored.
- Simultaneous events:
  - Row completion into bank X and show_row_done freeing bank Y on the same cycle are both applied. The full-flag set and clear never target the same bank, by construction.
  - If completion wants an ack and show_row_done also frees the new fill bank, exactly one credit is added.
  - A credit increment and a tx accept on the same cycle leave the count unchanged.
- Latency: last byte's rx_valid -> row_start no earlier than 2 cycles later (full registered, then FSM pulse).

Decomposition:
- Shared package lcd_pkg: ROW_BYTES, ROWS, ACK_BYTE, ADDR_W, and the read FSM state encoding (IDLE, DRAW).
- One natural sub-module, ack_credit_tx: the saturating credit counter plus the tx_valid/tx_ready handshake.
- Bank flags, the write pointer and the read FSM stay in the top level.

Test Plan:
- Reset release with tx_ready=1 -> exactly one tx_valid cycle with tx_data=0x41; no further acks; row_y=0, overrun=0.
- Send 480 bytes 0x00..0xDF (wrapping) -> 480 wr_en pulses, wr_bank=0, wr_addr 0..479; row_start with rd_bank=0; second 0x41 sent immediately.
- Send a second row before show_row_done -> bank B full, no ack; pulse show_row_done -> ack 0x41 within 2 cycles, rd_bank=1, row_start for B, row_y=1.
- With both banks full, send 1 byte -> no wr_en, overrun=1 and sticky until rst_n low.
- Hold tx_ready=0 for 50 cycles with credit pending -> tx_valid stays 1, tx_data stays 0x41; release -> single accept, credit drops.
- Stream 320 rows with immediate show_row_done -> frame_done pulses once after row 319, row_y=0; rst_n low after 100 bytes of a row -> next row writes restart at wr_addr=0, bank A.
